soc_system_cpu_cpu_mult_result: RTL and testbench

SOC_SYSTEM_CPU_CPU_MULT_RESULT -- requirements
Module: soc_system_cpu_cpu_mult_result

---
 rtl/soc_system_cpu_cpu_mult_result_if.sv | 30 +++
 rtl/soc_system_cpu_cpu_mult_result.sv | 186 ++++++++++++++++++
 tb/tb_soc_system_cpu_cpu_mult_result.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/soc_system_cpu_cpu_mult_result_if.sv
// Multiply result path bundle: M-stage partial products in, W-stage results out.
// "master" is the upstream pipeline plus the writeback consumer; "slave" is the result block.
interface soc_system_cpu_cpu_mult_result_if #(
    parameter int DST_W = 5
);
    logic [31:0]      M_mul_cell_p1;
    logic [31:0]      M_mul_cell_p2;
    logic [31:0]      M_mul_cell_p3;
    logic             M_en;
    logic             M_mul_valid;
    logic [DST_W-1:0] M_mul_dst;
    logic             M_mul_flush;
    logic             M_mul_stall;
    logic             W_mul_valid;
    logic [31:0]      W_mul_result;
    logic [DST_W-1:0] W_mul_dst;
    logic             W_mul_ready;

    modport master (
        output M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3, M_en, M_mul_valid,
        output M_mul_dst, M_mul_flush, W_mul_ready,
        input  M_mul_stall, W_mul_valid, W_mul_result, W_mul_dst
    );

    modport slave (
        input  M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3, M_en, M_mul_valid,
        input  M_mul_dst, M_mul_flush, W_mul_ready,
        output M_mul_stall, W_mul_valid, W_mul_result, W_mul_dst
    );
endinterface

// File: rtl/soc_system_cpu_cpu_mult_result.sv
// Combines three 16x16 partial products into a 32-bit multiply result through two
// fixed stages and a credit-protected output FIFO.
module soc_system_cpu_cpu_mult_result #(
    parameter int DST_W      = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    soc_system_cpu_cpu_mult_result_if.slave    bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;
    typedef struct packed {
        logic [DST_W-1:0] dst;
        logic [31:0]      res;
    } entry_t;

    localparam cnt_t OCC_FULL = cnt_t'(FIFO_DEPTH);

    logic             a_vld_q, a_vld_d;
    logic [31:0]      a_p1_q, a_p1_d;
    logic [15:0]      a_mid_q, a_mid_d;
    logic [DST_W-1:0] a_dst_q, a_dst_d;
    logic             b_vld_q, b_vld_d;
    logic [31:0]      b_res_q, b_res_d;
    logic [DST_W-1:0] b_dst_q, b_dst_d;
    entry_t           mem_q [FIFO_DEPTH];
    entry_t           mem_d [FIFO_DEPTH];
    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    cnt_t             fifo_cnt_q, fifo_cnt_d;
    cnt_t             occ_q, occ_d;
    logic             stall_q, stall_d;
    logic             w_vld_q, w_vld_d;
    logic [31:0]      w_res_q, w_res_d;
    logic [DST_W-1:0] w_dst_q, w_dst_d;
    logic             accept_s;
    logic             pop_s;
    entry_t           head_s;
    logic             unused_hi_s;

    // The upper halves of the cross products only ever land above bit 31.
    assign unused_hi_s = ^{bus.M_mul_cell_p2[31:16], bus.M_mul_cell_p3[31:16]};

    assign accept_s = bus.M_en & bus.M_mul_valid & ~stall_q & ~bus.M_mul_flush;
    assign pop_s    = w_vld_q & bus.W_mul_ready & ~bus.M_mul_flush;

    assign bus.M_mul_stall  = stall_q;
    assign bus.W_mul_valid  = w_vld_q;
    assign bus.W_mul_result = w_res_q;
    assign bus.W_mul_dst    = w_dst_q;

    // Next-state for both stages, FIFO, occupancy credit and output registers.
    always_comb begin
        a_vld_d = accept_s;
        a_p1_d  = a_p1_q;
        a_mid_d = a_mid_q;
        a_dst_d = a_dst_q;
        if (accept_s) begin
            a_p1_d  = bus.M_mul_cell_p1;
            a_mid_d = bus.M_mul_cell_p2[15:0] + bus.M_mul_cell_p3[15:0];
            a_dst_d = bus.M_mul_dst;
        end else begin
            a_p1_d  = a_p1_q;
            a_mid_d = a_mid_q;
            a_dst_d = a_dst_q;
        end

        b_vld_d = a_vld_q;
        b_res_d = a_p1_q + {a_mid_q, 16'h0000};
        b_dst_d = a_dst_q;

        for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (b_vld_q) begin
            mem_d[wr_ptr_q] = '{dst: b_dst_q, res: b_res_q};
            wr_ptr_d        = wr_ptr_q + ptr_t'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        fifo_cnt_d = fifo_cnt_q + cnt_t'(b_vld_q) - cnt_t'(pop_s);
        // Credit covers stage A, stage B and the FIFO, so a B write always has room.
        occ_d      = occ_q + cnt_t'(accept_s) - cnt_t'(pop_s);

        if (bus.M_mul_flush) begin
            a_vld_d    = 1'b0;
            b_vld_d    = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
            occ_d      = '0;
        end else begin
            a_vld_d = a_vld_d;
        end

        stall_d = (occ_d == OCC_FULL);
        head_s  = mem_d[rd_ptr_d];
        w_vld_d = (fifo_cnt_d != cnt_t'(1'b0));
        if (w_vld_d) begin
            w_res_d = head_s.res;
            w_dst_d = head_s.dst;
        end else begin
            w_res_d = w_res_q;
            w_dst_d = w_dst_q;
        end
    end

    // Control state and registered outputs, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_vld_q    <= 1'b0;
            b_vld_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            occ_q      <= '0;
            stall_q    <= 1'b0;
            w_vld_q    <= 1'b0;
            w_res_q    <= 32'h0000_0000;
            w_dst_q    <= '0;
        end else begin
            a_vld_q    <= a_vld_d;
            b_vld_q    <= b_vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            occ_q      <= occ_d;
            stall_q    <= stall_d;
            w_vld_q    <= w_vld_d;
            w_res_q    <= w_res_d;
            w_dst_q    <= w_dst_d;
        end
    end

    // Datapath storage; only meaningful alongside its valid bit.
    always_ff @(posedge clk) begin
        a_p1_q  <= a_p1_d;
        a_mid_q <= a_mid_d;
        a_dst_q <= a_dst_d;
        b_res_q <= b_res_d;
        b_dst_q <= b_dst_d;
        mem_q   <= mem_d;
    end

    soc_system_cpu_cpu_mult_result_chk #(
        .AW         (AW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_chk (
        .clk      (clk),
        .reset    (reset),
        .b_vld    (b_vld_q),
        .fifo_cnt (fifo_cnt_q),
        .occ      (occ_q)
    );
endmodule

// Watches the credit invariants of the result path.
module soc_system_cpu_cpu_mult_result_chk #(
    parameter int AW         = 2,
    parameter int FIFO_DEPTH = 4
) (
    input logic          clk,
    input logic          reset,
    input logic          b_vld,
    input logic [AW:0]   fifo_cnt,
    input logic [AW:0]   occ
);
    typedef logic [AW:0] cnt_t;
    localparam cnt_t FULL = cnt_t'(FIFO_DEPTH);

    a_no_full_write: assert property (@(posedge clk) disable iff (reset)
        !(b_vld && (fifo_cnt == FULL)));
    a_occ_bound: assert property (@(posedge clk) disable iff (reset)
        (occ <= FULL));
endmodule

// File: tb/tb_soc_system_cpu_cpu_mult_result.sv
// Randomized and directed stimulus against a transaction-level queue model.
module tb_soc_system_cpu_cpu_mult_result;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   cyc;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  dst;
        int          rdy;
    } item_t;
    item_t exp_q[$];

    soc_system_cpu_cpu_mult_result_if #(.DST_W(5)) bus ();

    soc_system_cpu_cpu_mult_result #(.DST_W(5), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, advance the model at the edge, check after it.
    task automatic step(input logic en, input logic vld, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] dst, input logic fl,
                        input logic rdy, input logic rs);
        logic  m_v, m_acc, m_pop;
        logic [63:0] prod;
        item_t it;
        @(negedge clk);
        bus.M_en          = en;
        bus.M_mul_valid   = vld;
        bus.M_mul_cell_p1 = {16'h0, a[15:0]} * {16'h0, b[15:0]};
        bus.M_mul_cell_p2 = {16'h0, a[15:0]} * {16'h0, b[31:16]};
        bus.M_mul_cell_p3 = {16'h0, a[31:16]} * {16'h0, b[15:0]};
        bus.M_mul_dst     = dst;
        bus.M_mul_flush   = fl;
        bus.W_mul_ready   = rdy;
        reset             = rs;
        m_v   = (exp_q.size() != 0) && (exp_q[0].rdy <= cyc);
        m_acc = en && vld && (exp_q.size() != 4) && !fl;
        m_pop = m_v && rdy && !fl;
        prod  = {32'h0, a} * {32'h0, b};
        @(posedge clk);
        cyc++;
        if (rs || fl) begin
            exp_q.delete();
        end else begin
            if (m_pop) void'(exp_q.pop_front());
            if (m_acc) begin
                it.res = prod[31:0];
                it.dst = dst;
                it.rdy = cyc + 2;
                exp_q.push_back(it);
            end
        end
        #1;
        m_v = (exp_q.size() != 0) && (exp_q[0].rdy <= cyc);
        chk_val("w_valid", bus.W_mul_valid, m_v);
        chk_val("stall", bus.M_mul_stall, exp_q.size() == 4);
        if (m_v) begin
            chk_val("w_result", bus.W_mul_result, exp_q[0].res);
            chk_val("w_dst", bus.W_mul_dst, exp_q[0].dst);
        end
        if (rs) begin
            chk_val("rst_result", bus.W_mul_result, 64'h0);
            chk_val("rst_dst", bus.W_mul_dst, 64'h0);
        end
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] dst,
                      input logic rdy);
        step(1'b1, 1'b1, a, b, dst, 1'b0, rdy, 1'b0);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        reset    = 1'b1;
        bus.M_en = 1'b0; bus.M_mul_valid = 1'b0; bus.M_mul_flush = 1'b0;
        bus.M_mul_cell_p1 = 32'h0; bus.M_mul_cell_p2 = 32'h0; bus.M_mul_cell_p3 = 32'h0;
        bus.M_mul_dst = 5'd0; bus.W_mul_ready = 1'b0;

        step(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);

        // Basic product, then the all-ones wrap case.
        op(32'h0003_0002, 32'h0005_0004, 5'd3, 1'b1);
        idle(4, 1'b1);
        op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b1);
        idle(4, 1'b1);

        // Fill with the consumer blocked, hold, then drain in order.
        for (int i = 0; i < 5; i++) op($urandom, $urandom, 5'(i + 1), 1'b0);
        idle(3, 1'b0);
        idle(8, 1'b1);

        // Full, then accept and pop together every cycle.
        for (int i = 0; i < 4; i++) op($urandom, $urandom, 5'(i + 10), 1'b0);
        idle(3, 1'b0);
        for (int i = 0; i < 8; i++) op($urandom, $urandom, 5'(i + 20), 1'b1);
        idle(6, 1'b1);

        // Flush with three in flight and a simultaneous valid input.
        for (int i = 0; i < 3; i++) op($urandom, $urandom, 5'(i + 4), 1'b0);
        step(1'b1, 1'b1, $urandom, $urandom, 5'd30, 1'b1, 1'b1, 1'b0);
        idle(5, 1'b1);

        // Reset one cycle after an accept, then a tagged op afterwards.
        op($urandom, $urandom, 5'd12, 1'b1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1);
        op(32'h0000_0007, 32'h0000_0006, 5'd7, 1'b1);
        idle(5, 1'b1);

        // Random traffic with occasional flushes and resets.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom, $urandom,
                 5'($urandom), $urandom_range(0, 40) == 0, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 150) == 0);
        end
        idle(6, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
